// File: rtl/three_way_gf2_mul_ds.sv
// Digit-serial carry-less multiplier over GF(2)[x] using a 3-way limb split.
// Nine limb products accumulate on five diagonals, then recombine once.
module three_way_gf2_mul_ds #(
  parameter int N     = 384,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] c
);

  localparam int K    = (N + 2) / 3;
  localparam int ITER = (K + DIGIT - 1) / DIGIT;
  localparam int CW   = $clog2(ITER) + 1;
  localparam int L    = 2 * K;
  localparam int W    = 6 * K;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COMB
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [K-1:0]   a_sh [3];
  logic [L-1:0]   b_sh [3];
  logic [L-1:0]   p    [3][3];
  logic [L-1:0]   acc_d;
  logic [L-1:0]   acc_e;
  logic [L-1:0]   acc_f;
  logic [L-1:0]   acc_g;
  logic [L-1:0]   acc_h;
  logic [3*K-1:0] ap;
  logic [3*K-1:0] bp;

  assign ap = (3*K)'(a);
  assign bp = (3*K)'(b);

  function automatic logic [L-1:0] clmul_digit(
    input logic [DIGIT-1:0] d,
    input logic [L-1:0]     v
  );
    logic [L-1:0] r;
    r = '0;
    for (int t = 0; t < DIGIT; t++)
      if (d[t]) r = r ^ (v << t);
    return r;
  endfunction

  // a limbs shift right and b limbs shift left, so the low digit
  // of a_sh times b_sh already carries the cnt*DIGIT weighting
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = clmul_digit(a_sh[i][DIGIT-1:0], b_sh[j]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= '0;
      acc_d <= '0;
      acc_e <= '0;
      acc_f <= '0;
      acc_g <= '0;
      acc_h <= '0;
      for (int i = 0; i < 3; i++) begin
        a_sh[i] <= '0;
        b_sh[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 3; i++) begin
              a_sh[i] <= ap[i*K +: K];
              b_sh[i] <= L'(bp[i*K +: K]);
            end
            acc_d <= '0;
            acc_e <= '0;
            acc_f <= '0;
            acc_g <= '0;
            acc_h <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc_d <= acc_d ^ p[2][2];
          acc_e <= acc_e ^ p[1][2] ^ p[2][1];
          acc_f <= acc_f ^ p[0][2] ^ p[1][1] ^ p[2][0];
          acc_g <= acc_g ^ p[0][1] ^ p[1][0];
          acc_h <= acc_h ^ p[0][0];
          for (int i = 0; i < 3; i++) begin
            a_sh[i] <= a_sh[i] >> DIGIT;
            b_sh[i] <= b_sh[i] << DIGIT;
          end
          if (cnt == CW'(ITER - 1)) state <= COMB;
          else cnt <= cnt + CW'(1);
        end
        COMB: begin
          c <= (2*N)'(W'(acc_h)
                    ^ (W'(acc_g) << K)
                    ^ (W'(acc_f) << (2*K))
                    ^ (W'(acc_e) << (3*K))
                    ^ (W'(acc_d) << (4*K)));
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
